// File: rtl/timer_responder_pkg.sv
// ---------------------------------------------------------------------------
// timer_responder_pkg
//
// Shared definitions for the memory-mapped countdown timer. The same package
// is imported by the bridge and the CPU address map, so the device base
// addresses and register offsets live here rather than in the timer itself.
//
// Contents:
//   state_t          2-bit FSM encoding (IDLE / LOAD / CNT / INT)
//   ADDR_*           word offsets within one device slot (address bits [3:2])
//   CTRL_*           bit positions inside the 4-bit CTRL register
//   MODE_*           countdown mode encodings
//   DEV0/DEV1_BASE   byte base addresses of the two timer slots
//   ctrl_word()      zero-extends CTRL to a 32-bit read value
//   is_reload()      decodes the auto-reload mode
// ---------------------------------------------------------------------------
package timer_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Register word offsets (bridge address bits [3:2]); offset 3 is unused.
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode encodings; 2'b10 and 2'b11 fall back to one-shot behaviour.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Byte base addresses of the two device slots behind the bridge.
    localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;

    function automatic logic [31:0] ctrl_word(input logic [3:0] c);
        return {28'b0, c};
    endfunction

    // Only the exact reload encoding reloads; every other mode is one-shot.
    function automatic logic is_reload(input logic [1:0] m);
        return (m == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_responder.sv
// ---------------------------------------------------------------------------
// timer_responder
//
// Device-side responder for one countdown-timer slot on the CPU-device
// bridge. Holds CTRL / PRESET / COUNT, runs a four-state countdown FSM and
// drives a level interrupt request.
//
// Ports:
//   clk      in   system clock, rising-edge
//   reset    in   asynchronous active-high reset, clears all state
//   Addr     in   [1:0] word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
//   WE       in   write strobe for this slot
//   DataIn   in   [31:0] write data
//   DataOut  out  [31:0] read data, combinational from Addr
//   IRQ      out  interrupt request = CTRL.IM & irq_flag
// ---------------------------------------------------------------------------
module timer_responder
    import timer_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic        count_zero;

    logic        wr_ctrl;
    logic        wr_preset;

    // FSM action strobes
    logic        load_cnt;
    logic        dec_cnt;
    logic        set_irq;
    logic        clr_irq_fsm;
    logic        clr_en;

    assign en         = ctrl[CTRL_EN];
    assign mode       = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign im         = ctrl[CTRL_IM];
    assign count_zero = (count == 32'd0);

    // Writes to COUNT (offset 2) and the unused offset 3 are simply not decoded.
    assign wr_ctrl    = WE && (Addr == ADDR_CTRL);
    assign wr_preset  = WE && (Addr == ADDR_PRESET);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic (sees register values from before the edge)
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (count_zero) begin
                    state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                state_nxt = is_reload(mode) ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM output logic: per-state action strobes for the register file
    // -----------------------------------------------------------------------
    always_comb begin
        load_cnt    = 1'b0;
        dec_cnt     = 1'b0;
        set_irq     = 1'b0;
        clr_irq_fsm = 1'b0;
        clr_en      = 1'b0;
        case (state)
            ST_LOAD: begin
                load_cnt = 1'b1;
            end
            ST_CNT: begin
                // COUNT never wraps: decrement only while nonzero.
                if (en && !count_zero) begin
                    dec_cnt = 1'b1;
                end
                if (en && count_zero) begin
                    set_irq = 1'b1;
                end
            end
            ST_INT: begin
                // Reload mode drops the flag after one cycle; one-shot keeps
                // it and turns itself off.
                if (is_reload(mode)) begin
                    clr_irq_fsm = 1'b1;
                end else begin
                    clr_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            // A CPU write to CTRL takes priority over the FSM's Enable clear.
            ctrl <= DataIn[3:0];
        end else if (clr_en) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            // Only sampled at LOAD, so a write mid-count leaves COUNT alone.
            preset <= DataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (load_cnt) begin
            count <= preset;
        end else if (dec_cnt) begin
            count <= count - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (set_irq) begin
            // The terminal-count event is never dropped by a coincident write.
            irq_flag <= 1'b1;
        end else if (wr_ctrl || wr_preset || clr_irq_fsm) begin
            irq_flag <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and interrupt output
    // -----------------------------------------------------------------------
    always_comb begin
        DataOut = 32'd0;
        case (Addr)
            ADDR_CTRL:   DataOut = ctrl_word(ctrl);
            ADDR_PRESET: DataOut = preset;
            ADDR_COUNT:  DataOut = count;
            default:     DataOut = 32'd0;
        endcase
    end

    assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_responder.sv
// ---------------------------------------------------------------------------
// tb_timer_responder
//
// Directed-vector bench for timer_responder. Inputs change 1 ns after a
// rising edge; reads settle a further 1 ns before sampling, so all samples
// land well away from the active edge. Expected values are hand-derived from
// the timing rules: with the enabling write at edge E, LOAD at E+1,
// COUNT=N at E+2, COUNT=0 at E+2+N, INT/IRQ at E+3+N.
// ---------------------------------------------------------------------------
module tb_timer_responder;
    import timer_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;

    int n_vec  = 0;
    int n_miss = 0;

    timer_responder dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word offset as the bridge would forward it from a full byte address.
    function automatic logic [1:0] slot_off(input logic [31:0] base, input logic [1:0] off);
        logic [31:0] a;
        a = base + {28'd0, off, 2'b00};
        return a[3:2];
    endfunction

    function automatic logic [31:0] mk_ctrl(input logic im, input logic [1:0] m, input logic e);
        logic [31:0] c;
        c = 32'd0;
        c[CTRL_IM] = im;
        c[CTRL_MODE_HI:CTRL_MODE_LO] = m;
        c[CTRL_EN] = e;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        Addr   = slot_off(DEV0_BASE, off);
        DataIn = d;
        WE     = 1'b1;
        @(posedge clk);
        #1;
        WE     = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        Addr = slot_off(DEV0_BASE, off);
        #1;
        chk(tag, DataOut, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        reset  = 1'b1;
        WE     = 1'b0;
        Addr   = 2'd0;
        DataIn = 32'd0;
        step(2);

        // ---- reset state ----
        chk_reg("rst_ctrl",   ADDR_CTRL,   32'd0);
        chk_reg("rst_preset", ADDR_PRESET, 32'd0);
        chk_reg("rst_count",  ADDR_COUNT,  32'd0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;

        // ---- reset in mid-count ----
        wr(ADDR_PRESET, 32'd5);
        wr(ADDR_CTRL, 32'h1);
        step(4);
        chk_reg("mid_count3", ADDR_COUNT, 32'd3);
        reset = 1'b1;
        #1;
        chk_reg("mid_rst_ctrl",   ADDR_CTRL,   32'd0);
        chk_reg("mid_rst_preset", ADDR_PRESET, 32'd0);
        chk_reg("mid_rst_count",  ADDR_COUNT,  32'd0);
        chk_irq("mid_rst_irq", 1'b0);
        wr(ADDR_CTRL, 32'h1);                  // ignored while reset is held
        step(3);
        chk_reg("rst_hold_ctrl",  ADDR_CTRL,  32'd0);
        chk_reg("rst_hold_count", ADDR_COUNT, 32'd0);
        reset = 1'b0;
        step(3);
        chk_reg("post_rst_count", ADDR_COUNT, 32'd0);

        // ---- mask: IM=0, PRESET=1 -> IRQ never asserts ----
        wr(ADDR_PRESET, 32'd1);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_irq($sformatf("mask_irq_%0d", k), 1'b0);
        end
        chk_reg("mask_ctrl_done", ADDR_CTRL, 32'h0);

        // ---- disable mid-count freezes COUNT ----
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h1);
        step(2);
        chk_reg("frz_load", ADDR_COUNT, 32'd10);
        step(3);
        chk_reg("frz_run", ADDR_COUNT, 32'd7);
        wr(ADDR_CTRL, 32'h0);
        chk_reg("frz_wr", ADDR_COUNT, 32'd6);
        step(3);
        chk_reg("frz_hold", ADDR_COUNT, 32'd6);

        // ---- auto-reload: PRESET=2, CTRL=0xB -> 1-cycle pulse every 5 ----
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, mk_ctrl(1'b1, MODE_RELOAD, 1'b1));
        for (int k = 1; k <= 12; k++) begin
            int p;
            logic [31:0] ec;
            step(1);
            p = (k + 3) % 5;                   // phase 0 at k=2 (COUNT=PRESET)
            chk_irq($sformatf("rld_irq_%0d", k), (k >= 2) && (p == 3));
            if (k >= 2) begin
                case (p)
                    0:       ec = 32'd2;
                    1:       ec = 32'd1;
                    default: ec = 32'd0;
                endcase
                chk_reg($sformatf("rld_cnt_%0d", k), ADDR_COUNT, ec);
            end
        end
        wr(ADDR_CTRL, 32'h0);
        step(1);

        // ---- one-shot: PRESET=3, CTRL=0x9 ----
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, mk_ctrl(1'b1, MODE_ONESHOT, 1'b1));
        chk_reg("os_ctrl", ADDR_CTRL, 32'h9);
        step(2);
        chk_reg("os_cnt3", ADDR_COUNT, 32'd3);
        step(1);
        chk_reg("os_cnt2", ADDR_COUNT, 32'd2);
        step(1);
        chk_reg("os_cnt1", ADDR_COUNT, 32'd1);
        step(1);
        chk_reg("os_cnt0", ADDR_COUNT, 32'd0);
        chk_irq("os_irq_pre", 1'b0);
        step(1);
        chk_irq("os_irq_rise", 1'b1);
        step(1);
        chk_reg("os_ctrl_after", ADDR_CTRL, 32'h8);
        chk_irq("os_irq_hold", 1'b1);
        step(3);
        chk_irq("os_irq_hold2", 1'b1);
        chk_reg("os_cnt_stay0", ADDR_COUNT, 32'd0);
        wr(ADDR_CTRL, 32'h8);
        chk_irq("os_irq_clr", 1'b0);

        // ---- mode 2 behaves as one-shot ----
        wr(ADDR_PRESET, 32'd1);
        wr(ADDR_CTRL, 32'hD);
        step(3);
        chk_irq("m2_irq_pre", 1'b0);
        step(1);
        chk_irq("m2_irq", 1'b1);
        step(1);
        chk_reg("m2_ctrl", ADDR_CTRL, 32'hC);
        step(2);
        chk_reg("m2_noreload", ADDR_COUNT, 32'd0);
        chk_irq("m2_irq_hold", 1'b1);
        wr(ADDR_CTRL, 32'h0);
        chk_irq("m2_irq_clr", 1'b0);

        // ---- PRESET=0: INT two cycles after LOAD ----
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        step(2);
        chk_reg("p0_cnt", ADDR_COUNT, 32'd0);
        chk_irq("p0_irq_pre", 1'b0);
        step(1);
        chk_irq("p0_irq", 1'b1);
        step(1);
        chk_reg("p0_ctrl", ADDR_CTRL, 32'h8);
        wr(ADDR_CTRL, 32'h0);

        // ---- write collision with INT ----
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h9);
        step(5);
        chk_irq("col_irq_int", 1'b1);
        wr(ADDR_CTRL, 32'h9);                  // lands on the INT edge
        chk_reg("col_ctrl", ADDR_CTRL, 32'h9);
        chk_irq("col_irq_clr", 1'b0);
        step(1);
        chk_reg("col_idle_cnt", ADDR_COUNT, 32'd0);
        step(1);
        chk_reg("col_reload", ADDR_COUNT, 32'd2);
        wr(ADDR_CTRL, 32'h0);
        step(1);
        chk_reg("col_frozen", ADDR_COUNT, 32'd1);

        // ---- writes to offsets 2 and 3 are ignored ----
        wr(ADDR_COUNT, 32'h0000_DEAD);
        wr(2'd3, 32'h0000_1234);
        chk_reg("ro_count", ADDR_COUNT, 32'd1);
        chk_reg("ro_addr3", 2'd3, 32'd0);
        chk_reg("ro_preset", ADDR_PRESET, 32'd2);
        chk_reg("ro_ctrl", ADDR_CTRL, 32'd0);
        Addr = slot_off(DEV1_BASE, ADDR_COUNT);
        #1;
        chk("ro_slot1_off", DataOut, 32'd1);

        // ---- PRESET write during CNT applies at the next LOAD ----
        wr(ADDR_PRESET, 32'd4);
        wr(ADDR_CTRL, 32'h1);
        step(3);
        chk_reg("pw_cnt3", ADDR_COUNT, 32'd3);
        wr(ADDR_PRESET, 32'd7);
        chk_reg("pw_cnt2", ADDR_COUNT, 32'd2);
        chk_reg("pw_preset", ADDR_PRESET, 32'd7);
        step(4);
        chk_reg("pw_done_ctrl", ADDR_CTRL, 32'h0);
        chk_reg("pw_done_cnt", ADDR_COUNT, 32'd0);
        wr(ADDR_CTRL, 32'h1);
        step(2);
        chk_reg("pw_newload", ADDR_COUNT, 32'd7);
        wr(ADDR_CTRL, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/timer_responder.md
# timer_responder

Memory-mapped countdown timer. It is the device-side responder on the CPU–device bridge bus. It decodes the word address and write strobe the bridge forwards, exposes three 32-bit registers (CTRL, PRESET, COUNT), runs a four-state countdown FSM, and raises an interrupt request to the CPU's exception logic. Two instances sit behind the bridge, one per device slot; each sees the same address/data/write-enable bus.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Addr  in  2  word offset within device (bridge address bits [3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
- WE  in  1  write strobe from bridge for this device slot.
- DataIn  in  32  write data.
- DataOut  out  32  read data; combinational from Addr.
- IRQ  out  1  interrupt request, level, = CTRL.IM & irq_flag.

## Operation
- CTRL is a 4-bit register.
  - [0] Enable.
  - [2:1] Mode: 00 = one-shot; 01 = auto-reload; 10/11 behave as 00.
  - [3] IM, interrupt mask (1 = IRQ enabled).
  - Reads return {28'b0, CTRL}.
- PRESET: 32-bit, read/write.
- COUNT: 32-bit, read-only; writes to Addr 2 or 3 are ignored. Addr 3 reads 0.
- irq_flag: internal, not addressable.
- A write to CTRL or PRESET (WE=1) clears irq_flag on the same edge.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable=1 → LOAD; else stay.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - if Enable=0 → IDLE, COUNT holds.
    - else if COUNT≠0, COUNT ← COUNT−1, stay.
    - else (COUNT=0) irq_flag ← 1, → INT.
  - INT, mode 0/2/3: Enable ← 0, → IDLE; irq_flag stays set until a CTRL/PRESET write or reset.
  - INT, mode 1: irq_flag ← 0, → LOAD, so IRQ is a one-cycle pulse.
- Simultaneous CPU write and FSM update:
  - The CPU write to CTRL wins over the FSM's Enable clear in INT.
  - The FSM observes register values as they were before the edge, so a write takes effect one cycle later.
- A PRESET write during CNT does not disturb the running COUNT; it applies at the next LOAD.
- PRESET=0: LOAD sets COUNT=0, and CNT goes to INT on the following edge.
- COUNT never wraps; decrement only when nonzero.
- Reset, including in mid-count: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Therefore IRQ=0 and DataOut reflects zeros.

## Timing
- Let edge E be the edge that commits CTRL.Enable=1 from IDLE.
- E+1: state=LOAD.
- E+2: COUNT=PRESET=N, state=CNT.
- E+2+N: COUNT=0.
- E+3+N: state=INT, irq_flag=1, so IRQ rises if IM=1.
- Mode 0: E+4+N, state=IDLE, Enable=0; IRQ stays high.
- Mode 1: E+4+N, IRQ low, state=LOAD; E+5+N, COUNT=N. The period is N+3 cycles and IRQ is high for exactly 1 cycle per period.
- Reads have zero latency (combinational). A value written at edge t is readable after t.

## Structure
- Shared package (with the bridge and CPU address map) holds:
  - state encoding (2-bit enum IDLE/LOAD/CNT/INT);
  - register offset constants: ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2;
  - CTRL bit positions (EN=0, MODE=2:1, IM=3) and mode constants MODE_ONESHOT=0, MODE_RELOAD=1;
  - device base addresses 0x7F00 and 0x7F10.
- No sub-module: register file, FSM and read mux fit in a single module.

## Test plan
- Reset in mid-count: PRESET=5, Enable; assert reset at COUNT=3 → every read returns 0, IRQ=0, and the state does not advance while reset is high.
- One-shot: PRESET=3, CTRL=0x9 (IM=1, mode 0, En) → COUNT reads 3,2,1,0. IRQ rises 1 cycle after COUNT=0 and stays high. CTRL reads 0x8. A subsequent CTRL write clears IRQ.
- Auto-reload: PRESET=2, CTRL=0xB → IRQ is a 1-cycle pulse every 5 cycles. COUNT sequence 2,1,0,0(INT),x(LOAD),2,…
- Mask and disable: CTRL=0x1 (IM=0) with PRESET=1 → IRQ never asserts; writing CTRL=0x0 mid-count freezes COUNT at its current value.
- Edge cases:
  - PRESET=0 with Enable → INT reached 2 cycles after LOAD.
  - Writes to Addr 2 and 3 leave COUNT unchanged.
  - A PRESET write during CNT leaves COUNT unaffected until the next reload.
- Write collision: in mode 0, write CTRL=0x9 on the same edge the FSM is in INT → Enable remains 1, irq_flag cleared, state goes to IDLE and then LOAD.
